demux_1to16_deserializer: RTL

//  Receive end of the 16:1 select path. Takes a serial bit stream (bit k of a
//  16-bit word presented as the 16:1 mux output with sel=k) and steers each bit

---
 rtl/mux_demux_pkg.sv | 12 +
 rtl/demux_1to16.sv | 19 +
 rtl/demux_1to16_deserializer.sv | 116 +++++++++++
 3 files changed

// File: rtl/mux_demux_pkg.sv
// Shared definitions for the 16:1 select path: word geometry and deserializer states.
package mux_demux_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned IDX_W  = $clog2(WORD_W);

  typedef enum logic {
    IDLE,
    RECV
  } deser_state_t;

endpackage

// File: rtl/demux_1to16.sv
// 1:WIDTH demux: steers one serial bit to a single position via a one-hot write enable.
module demux_1to16
  import mux_demux_pkg::*;
#(
  parameter  int unsigned WIDTH = WORD_W,
  localparam int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic             din,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] we,
  output logic [WIDTH-1:0] wdata_c
);

  assign we      = WIDTH'(en) << sel;
  // Data lane pre-masked by the enable so the target register can merge with a single OR.
  assign wdata_c = {WIDTH{din}} & we;

endmodule

// File: rtl/demux_1to16_deserializer.sv
// Serial-to-word receiver: demuxes each accepted bit into an assembly register and
// hands complete words to a one-word holding register behind a valid/ready handshake.
module demux_1to16_deserializer
  import mux_demux_pkg::WORD_W;
#(
  parameter  int unsigned WIDTH = WORD_W,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [IDX_W-1:0] bit_idx,
  output logic             overrun,
  output logic             framing_err,
  input  logic             clr_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  mux_demux_pkg::deser_state_t state, state_nxt;

  logic [WIDTH-1:0] assembly, assembly_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic [IDX_W-1:0] bit_idx_nxt;
  logic             dout_valid_nxt, overrun_nxt, framing_err_nxt;
  logic             complete_c;

  logic             wr_en_c;
  logic [IDX_W-1:0] sel_c;
  logic [WIDTH-1:0] we, wdata;

  // A start bit always lands at position 0, whatever the current state.
  assign wr_en_c = sin_valid & (sin_start | (state == mux_demux_pkg::RECV));
  assign sel_c   = sin_start ? '0 : bit_idx;

  demux_1to16 #(.WIDTH(WIDTH)) u_demux (
    .din     (sin),
    .en      (wr_en_c),
    .sel     (sel_c),
    .we      (we),
    .wdata_c (wdata)
  );

  assign assembly_nxt = (assembly & ~we) | wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= mux_demux_pkg::IDLE;
      bit_idx     <= '0;
      assembly    <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_idx     <= bit_idx_nxt;
      assembly    <= assembly_nxt;
      dout        <= dout_nxt;
      dout_valid  <= dout_valid_nxt;
      overrun     <= overrun_nxt;
      framing_err <= framing_err_nxt;
    end
  end

  // Next state, frame position, holding register and sticky flags.
  always_comb begin
    state_nxt       = state;
    bit_idx_nxt     = bit_idx;
    dout_nxt        = dout;
    dout_valid_nxt  = dout_valid & ~dout_ready;
    overrun_nxt     = overrun & ~clr_err;
    framing_err_nxt = framing_err & ~clr_err;
    complete_c      = 1'b0;

    case (state)
      mux_demux_pkg::IDLE: begin
        if (sin_valid && sin_start) begin
          state_nxt   = mux_demux_pkg::RECV;
          bit_idx_nxt = IDX_W'(1);
        end
      end
      mux_demux_pkg::RECV: begin
        if (sin_valid) begin
          if (sin_start) begin
            framing_err_nxt = 1'b1;
            bit_idx_nxt     = IDX_W'(1);
          end else if (bit_idx == LAST_IDX) begin
            complete_c  = 1'b1;
            bit_idx_nxt = '0;
            state_nxt   = mux_demux_pkg::IDLE;
          end else begin
            bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = mux_demux_pkg::IDLE;
    endcase

    // The last bit is already merged in assembly_nxt, so it is the finished word.
    if (complete_c) begin
      if (!dout_valid || dout_ready) begin
        dout_nxt       = assembly_nxt;
        dout_valid_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end
  end

endmodule
